pipe_stage_skid_reg: RTL and testbench
======================================

// Module: pipe_stage_skid_reg
// PURPOSE
//  Generic inter-stage pipeline register for the RISC-V core (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Replaces fixed-width stall/flush registers with a parametrised valid/ready stage backed by a 2-entry skid buffer.
//  Keeps full throughput under back-pressure and breaks the ready path combinationally.
//  Supports flush-to-bubble and a saturating count of beats discarded by flushes.
// PARAMETERS
//  DATA_W       32    width of the payload bundle (e.g. {PC, INSTRUCTION} = 64)
//  RESET_VALUE  0     DATA_W-bit value loaded into both entries on RESET
//  FLUSH_VALUE  0     DATA_W-bit bubble value loaded into both entries on FLUSH (NOP encoding allowed)
//  CNT_W        8     width of DROP_CNT
// PORTS
//  CLK        in   1       clock, rising edge
//  RESET      in   1       synchronous, active-high reset
//  FLUSH      in   1       discard all held and incoming beats (branch taken / exception)
//  IN_VALID   in   1       upstream beat valid
//  IN_READY   out  1       stage can accept a beat; driven only from state register
//  IN_DATA    in   DATA_W  upstream payload
//  OUT_VALID  out  1       OUT_DATA holds a valid beat
//  OUT_READY  in   1       downstream accepts the beat
//  OUT_DATA   out  DATA_W  payload from main entry
//  OCCUPANCY  out  2       beats held: 0, 1 or 2
//  DROP_CNT   out  CNT_W   saturating count of valid beats discarded by FLUSH
// BEHAVIOUR
//  - Clock is CLK; reset is synchronous and active-high (RESET sampled on CLK rising edge only).
//  - Handshake: in_fire = IN_VALID & IN_READY; out_fire = OUT_VALID & OUT_READY.
//  - IN_VALID must not depend on IN_READY; IN_DATA is captured only on in_fire.
//  - State register, 3 states: EMPTY (0 beats), BUSY (main entry valid), FULL (main + skid valid).
//  - Outputs decoded from state only:
//    - OUT_VALID = (state != EMPTY); IN_READY = (state != FULL); OUT_DATA = main.
//    - OCCUPANCY = 0, 1 or 2 for EMPTY, BUSY or FULL.
//  - Priority per edge: RESET > FLUSH > normal transfer.
//  - RESET: state <= EMPTY; main, skid <= RESET_VALUE; DROP_CNT <= 0.
//    - Outputs after reset: OUT_VALID=0, IN_READY=1, OUT_DATA=RESET_VALUE, OCCUPANCY=0.
//  - FLUSH (no RESET): state <= EMPTY; main, skid <= FLUSH_VALUE.
//    - A beat handshaken (in_fire) in the flush cycle is consumed and discarded.
//    - A beat consumed by downstream (out_fire) in the flush cycle counts as delivered.
//    - DROP_CNT += OCCUPANCY + in_fire - out_fire, saturating at 2^CNT_W-1 (no wrap).
//  - Normal transfers:
//    - EMPTY: in_fire -> BUSY, main <= IN_DATA.
//    - BUSY:  in_fire & out_fire -> BUSY, main <= IN_DATA.
//    - BUSY:  in_fire & !out_fire -> FULL, skid <= IN_DATA.
//    - BUSY:  !in_fire & out_fire -> EMPTY.
//    - BUSY:  neither -> hold.
//    - FULL:  out_fire -> BUSY, main <= skid (IN_READY=0, so no in_fire possible).
//    - FULL:  no out_fire -> hold.
//  - Latency: IN_DATA accepted at edge N appears on OUT_DATA with OUT_VALID=1 after edge N.
//  - Throughput: 1 beat/cycle while OUT_READY=1. Order is strictly FIFO; no beat is duplicated or lost except by FLUSH.
//  - When EMPTY, OUT_DATA keeps its last-loaded value (last beat, RESET_VALUE or FLUSH_VALUE); consumers qualify with OUT_VALID.
//  - OUT_VALID may fall only after out_fire, FLUSH or RESET.
//  - Main and skid entries never change while their state holds.
// TESTING
//  1 Reset: assert RESET 2 cycles mid-FULL -> OUT_VALID=0, IN_READY=1, OCCUPANCY=0, DROP_CNT=0, OUT_DATA=RESET_VALUE.
//  2 Streaming: OUT_READY=1, push 0x11..0x18 back-to-back
//    -> each appears 1 cycle later in order, OCCUPANCY stays 1, IN_READY stays 1.
//  3 Back-pressure: BUSY with 0xA1, OUT_READY=0, push 0xA2 -> FULL, IN_READY=0.
//    Raise OUT_READY -> 0xA1 then 0xA2 delivered, state returns to EMPTY.
//  4 Flush in FULL with in_fire=0, out_fire=0 -> EMPTY next cycle, OUT_DATA=FLUSH_VALUE, DROP_CNT += 2.
//    Flush in BUSY with in_fire=1, out_fire=1 -> DROP_CNT += 1.
//  5 Saturation: CNT_W=2, issue 3 FULL flushes -> DROP_CNT 2, 3, 3 (no wrap).
//  6 Random valid/ready (10k cycles) against a reference FIFO model -> exact sequence match and no handshake-rule violation.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
// Valid/ready pipeline stage backed by a two-entry skid buffer.
// IN_READY and all outputs are decoded from registered state; FLUSH drops beats into a saturating counter.
module pipe_stage_skid_reg #(
    parameter int unsigned          DATA_W      = 32,
    parameter logic [DATA_W-1:0]    RESET_VALUE = '0,
    parameter logic [DATA_W-1:0]    FLUSH_VALUE = '0,
    parameter int unsigned          CNT_W       = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [1:0]        OCCUPANCY,
    output logic [CNT_W-1:0]  DROP_CNT
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam int unsigned      SUM_W   = CNT_W + 2;
    localparam logic [SUM_W-1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   main_q, main_d;
    logic [DATA_W-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic                in_fire, out_fire;
    logic [SUM_W-1:0]    drop_sum;

    always_comb begin
        IN_READY  = (state_q != ST_FULL);
        OUT_VALID = (state_q != ST_EMPTY);
        OUT_DATA  = main_q;
        DROP_CNT  = drop_cnt_q;
        case (state_q)
            ST_BUSY: OCCUPANCY = 2'd1;
            ST_FULL: OCCUPANCY = 2'd2;
            default: OCCUPANCY = 2'd0;
        endcase
    end

    assign in_fire  = IN_VALID & IN_READY;
    assign out_fire = OUT_VALID & OUT_READY;

    always_comb begin
        state_d    = state_q;
        main_d     = main_q;
        skid_d     = skid_q;
        drop_cnt_d = drop_cnt_q;
        drop_sum   = '0;
        if (FLUSH) begin
            // out_fire implies OCCUPANCY >= 1, so the sum cannot underflow
            drop_sum   = SUM_W'(drop_cnt_q) + SUM_W'(OCCUPANCY) + SUM_W'(in_fire) - SUM_W'(out_fire);
            drop_cnt_d = (drop_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : drop_sum[CNT_W-1:0];
            state_d    = ST_EMPTY;
            main_d     = FLUSH_VALUE;
            skid_d     = FLUSH_VALUE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_BUSY;
                        main_d  = IN_DATA;
                    end
                end
                ST_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = IN_DATA;
                    end else if (in_fire) begin
                        state_d = ST_FULL;
                        skid_d  = IN_DATA;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d = ST_BUSY;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_EMPTY;
            main_q     <= RESET_VALUE;
            skid_q     <= RESET_VALUE;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench for pipe_stage_skid_reg: directed scenarios plus random valid/ready traffic
// compared against a queue-based reference model; a second instance with a 2-bit counter covers saturation.
module tb_pipe_stage_skid_reg;

    localparam logic [31:0] RST_VAL = 32'hDEAD_BEEF;
    localparam logic [31:0] FL_VAL  = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RESET, FLUSH, IN_VALID, OUT_READY;
    logic [31:0] IN_DATA;
    logic        in_ready, out_valid, in_ready_s, out_valid_s;
    logic [31:0] out_data, out_data_s;
    logic [1:0]  occupancy, occupancy_s;
    logic [7:0]  drop_cnt;
    logic [1:0]  drop_cnt_s;

    always #5 CLK = ~CLK;

    pipe_stage_skid_reg #(.DATA_W(32), .RESET_VALUE(RST_VAL), .FLUSH_VALUE(FL_VAL), .CNT_W(8)) dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(in_ready), .IN_DATA(IN_DATA),
        .OUT_VALID(out_valid), .OUT_READY(OUT_READY), .OUT_DATA(out_data),
        .OCCUPANCY(occupancy), .DROP_CNT(drop_cnt)
    );

    pipe_stage_skid_reg #(.DATA_W(32), .RESET_VALUE(RST_VAL), .FLUSH_VALUE(FL_VAL), .CNT_W(2)) dut_sat (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(in_ready_s), .IN_DATA(IN_DATA),
        .OUT_VALID(out_valid_s), .OUT_READY(OUT_READY), .OUT_DATA(out_data_s),
        .OCCUPANCY(occupancy_s), .DROP_CNT(drop_cnt_s)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: FIFO of held beats, last value seen at the head, total beats dropped.
    logic [31:0] mdl_q[$];
    logic [31:0] mdl_last;
    int unsigned mdl_drop;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] sat(input int unsigned v, input int unsigned max);
        return (v > max) ? 64'(max) : 64'(v);
    endfunction

    task automatic check_outputs();
        logic [31:0] exp_data;
        exp_data = (mdl_q.size() > 0) ? mdl_q[0] : mdl_last;
        check("out_valid", 64'(out_valid), 64'(mdl_q.size() > 0));
        check("in_ready",  64'(in_ready),  64'(mdl_q.size() < 2));
        check("occupancy", 64'(occupancy), 64'(mdl_q.size()));
        check("out_data",  64'(out_data),  64'(exp_data));
        check("drop_cnt",  64'(drop_cnt),  sat(mdl_drop, 255));
        check("drop_sat",  64'(drop_cnt_s), sat(mdl_drop, 3));
        check("sat_data",  64'(out_data_s), 64'(exp_data));
    endtask

    // One clock: drive inputs, check current outputs, advance model with the same handshakes.
    task automatic cycle(input logic rst, input logic fl, input logic iv,
                         input logic [31:0] d, input logic ordy);
        bit infire, outfire;
        RESET = rst; FLUSH = fl; IN_VALID = iv; IN_DATA = d; OUT_READY = ordy;
        check_outputs();
        infire  = iv && (mdl_q.size() < 2);
        outfire = ordy && (mdl_q.size() > 0);
        @(posedge CLK);
        if (rst) begin
            mdl_q.delete(); mdl_drop = 0; mdl_last = RST_VAL;
        end else if (fl) begin
            mdl_drop = mdl_drop + mdl_q.size() + int'(infire) - int'(outfire);
            mdl_q.delete(); mdl_last = FL_VAL;
        end else begin
            if (outfire) void'(mdl_q.pop_front());
            if (infire)  mdl_q.push_back(d);
        end
        if (mdl_q.size() > 0) mdl_last = mdl_q[0];
        #1;
    endtask

    initial begin
        RESET = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; IN_DATA = '0; OUT_READY = 1'b0;
        @(posedge CLK); #1;
        mdl_q.delete(); mdl_drop = 0; mdl_last = RST_VAL;

        // Reset asserted for two cycles while FULL
        cycle(0, 0, 1, 32'h0000_0001, 0);
        cycle(0, 0, 1, 32'h0000_0002, 0);
        check("full_before_rst", 64'(occupancy), 64'd2);
        cycle(1, 0, 1, 32'h0000_0003, 0);
        cycle(1, 0, 0, 32'h0, 0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_occ",   64'(occupancy), 64'd0);
        check("rst_drop",  64'(drop_cnt), 64'd0);
        check("rst_data",  64'(out_data), 64'(RST_VAL));

        // Streaming 0x11..0x18 back-to-back
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 1, 32'h11 + 32'(i), 1);
            check("stream_data", 64'(out_data), 64'(32'h11 + 32'(i)));
            check("stream_occ",  64'(occupancy), 64'd1);
            check("stream_rdy",  64'(in_ready), 64'd1);
        end
        cycle(0, 0, 0, 32'h0, 1);
        check("stream_drain", 64'(out_valid), 64'd0);

        // Back-pressure
        cycle(0, 0, 1, 32'hA1, 0);
        cycle(0, 0, 1, 32'hA2, 0);
        check("bp_full_rdy", 64'(in_ready), 64'd0);
        check("bp_full_occ", 64'(occupancy), 64'd2);
        check("bp_head", 64'(out_data), 64'h0A1);
        cycle(0, 0, 0, 32'h0, 1);
        check("bp_second", 64'(out_data), 64'h0A2);
        cycle(0, 0, 0, 32'h0, 1);
        check("bp_empty", 64'(out_valid), 64'd0);
        check("bp_hold_data", 64'(out_data), 64'h0A2);

        // Flush in FULL, then flush in BUSY with both handshakes
        cycle(0, 0, 1, 32'hB1, 0);
        cycle(0, 0, 1, 32'hB2, 0);
        cycle(0, 1, 0, 32'h0, 0);
        check("fl_full_drop", 64'(drop_cnt), 64'd2);
        check("fl_full_data", 64'(out_data), 64'(FL_VAL));
        check("fl_full_vld",  64'(out_valid), 64'd0);
        cycle(0, 0, 1, 32'hC1, 0);
        cycle(0, 1, 1, 32'hC2, 1);
        check("fl_busy_drop", 64'(drop_cnt), 64'd3);
        check("fl_busy_vld",  64'(out_valid), 64'd0);

        // Saturation of the 2-bit counter over three FULL flushes
        cycle(1, 0, 0, 32'h0, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 1, 32'hD0 + 32'(k), 0);
            cycle(0, 0, 1, 32'hE0 + 32'(k), 0);
            cycle(0, 1, 0, 32'h0, 0);
            check("sat_cnt", 64'(drop_cnt_s), (k == 0) ? 64'd2 : 64'd3);
        end
        check("nosat_cnt", 64'(drop_cnt), 64'd6);

        // Random traffic
        for (int n = 0; n < 10000; n++) begin
            cycle(($urandom % 3000) == 0, ($urandom % 50) == 0, ($urandom % 4) != 0,
                  $urandom, ($urandom % 3) != 0);
        end
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
